axil_cfg_master: RTL and testbench
==================================

AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 5, byte-address width of AXI-Lite and cmd_addr.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, data width (fixed 32; WSTRB always all-ones).
REQ-003 Parameter TIMEOUT_CYCLES, default 256, watchdog limit per transaction (used only with AXIL_MASTER_TIMEOUT_EN).
REQ-004 Single clock M_AXI_ACLK; reset M_AXI_ARESET is synchronous and active-high.
REQ-005 M_AXI_ACLK  in  1  clock, all logic on rising edge.
REQ-006 M_AXI_ARESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  word index; byte address driven = cmd_addr << 2, truncated to ADDR_W.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  one-cycle pulse, transaction complete.
REQ-012 rsp_rdata  out  32  read data (0 for writes), held until next rsp_valid.
REQ-013 rsp_resp  out  2  BRESP/RRESP of completed transaction.
REQ-014 rsp_timeout  out  1  transaction aborted by watchdog (constant 0 without macro).
REQ-015 M_AXI_AWADDR, AWPROT(3, tied 0), AWVALID out; AWREADY in.
REQ-016 M_AXI_WDATA, WSTRB(4, all-ones), WVALID out; WREADY in.
REQ-017 M_AXI_BRESP(2), BVALID in; BREADY out.
REQ-018 M_AXI_ARADDR, ARPROT(3, tied 0), ARVALID out; ARREADY in.
REQ-019 M_AXI_RDATA(32), RRESP(2), RVALID in; RREADY out.

Function
REQ-020 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-021 cmd_ready = 1 only in IDLE; command accepted on cmd_valid & cmd_ready; addr/data registered.
REQ-022 Accepted write: next cycle AWVALID=WVALID=1 (WR_REQ); accepted read: next cycle ARVALID=1 (RD_REQ).
REQ-023 AWVALID and WVALID deassert independently, each on the cycle after its own VALID&READY; AW/W may complete in either order or together.
REQ-024 WR_REQ -> WR_RESP once both AW and W handshakes done; BREADY=1 only in WR_RESP.
REQ-025 RD_REQ -> RD_DATA on ARVALID&ARREADY; RREADY=1 only in RD_DATA.
REQ-026 BVALID&BREADY or RVALID&RREADY -> DONE; DONE asserts rsp_valid one cycle, returns to IDLE next cycle.
REQ-027 Minimum write latency with zero-wait slave: cmd accept to rsp_valid = 4 cycles; read = 4 cycles.
REQ-028 VALID signals, once asserted, stay asserted with stable addr/data until handshake (AXI rule).
REQ-029 BVALID/RVALID arriving outside WR_RESP/RD_DATA ignored; no READY driven.
REQ-030 rsp_resp copies BRESP/RRESP unchanged; SLVERR/DECERR not retried.
REQ-031 One outstanding transaction max; no reordering.

Reset
REQ-032 On M_AXI_ARESET: state IDLE, all VALID/READY outputs 0, cmd_ready 0 during reset cycle then 1, rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0, address/data regs 0.
REQ-033 Reset mid-transaction abandons it silently; no rsp_valid issued for it.

Configuration
REQ-034 Macro AXIL_MASTER_TIMEOUT_EN: when defined, counter clears on cmd accept, increments each cycle outside IDLE/DONE; at TIMEOUT_CYCLES drop all VALID/READY, go DONE, rsp_valid=1, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-035 Without AXIL_MASTER_TIMEOUT_EN: no counter, waits indefinitely, rsp_timeout tied 0.

Verification
REQ-036 Write cmd_addr=2, data 0x00000100, zero-wait slave -> AWADDR=0x08, WDATA=0x100, rsp_valid 4 cycles after accept, rsp_resp=0.
REQ-037 Write with AWREADY delayed 5 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 6 cycles, single rsp_valid.
REQ-038 Read cmd_addr=3, slave RDATA=0xDEADBEEF after 3 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=0, ARADDR=0x0C stable throughout.
REQ-039 Slave BRESP=2'b10 -> rsp_resp=2'b10, rsp_timeout=0.
REQ-040 Reset asserted in WR_RESP -> all outputs reset values next cycle, no rsp_valid, next command executes normally.
REQ-041 With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops, rsp_valid with rsp_timeout=1, rsp_resp=2'b10; without macro ARVALID held indefinitely.

Source files
------------

// File: rtl/axil_cfg_master_if.sv
// AXI4-Lite bus bundle between axil_cfg_master and a slave.
// Signals:
//   AW channel: M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID (master -> slave);
//               M_AXI_AWREADY (slave -> master).
//   W channel:  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID (master -> slave);
//               M_AXI_WREADY (slave -> master).
//   B channel:  M_AXI_BRESP, M_AXI_BVALID (slave -> master); M_AXI_BREADY (master -> slave).
//   AR channel: M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID (master -> slave);
//               M_AXI_ARREADY (slave -> master).
//   R channel:  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID (slave -> master);
//               M_AXI_RREADY (master -> slave).
// Modports: master (the config master), slave (a bus target or a bench model).
interface axil_cfg_master_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                      M_AXI_AWPROT;
  logic                            M_AXI_AWVALID;
  logic                            M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID;
  logic                            M_AXI_WREADY;
  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID;
  logic                            M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                      M_AXI_ARPROT;
  logic                            M_AXI_ARVALID;
  logic                            M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID;
  logic                            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite configuration master.
// A word-indexed command (cmd_*) becomes one AXI-Lite write or read; completion is reported as a
// one-cycle rsp_valid pulse with the slave's response code and (for reads) data.
// Ports:
//   M_AXI_ACLK    clock, rising edge
//   M_AXI_ARESET  synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_write, cmd_addr (word index), cmd_wdata   command handshake
//   rsp_valid (pulse), rsp_rdata, rsp_resp, rsp_timeout               completion report
//   m_axi         AXI-Lite master side (axil_cfg_master_if.master)
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to add a per-transaction watchdog that aborts
// after TIMEOUT_CYCLES busy cycles (rsp_timeout=1, rsp_resp=SLVERR). Without it the master waits
// indefinitely and rsp_timeout is tied low.
module axil_cfg_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  axil_cfg_master_if.master             m_axi
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StDone
  } state_e;

  state_e                          state_q, state_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Every handshake output is gated by reset so a slave never sees a handshake completed during
  // the reset cycle of a transaction that is being abandoned.
  always_comb begin
    cmd_ready           = (state_q == StIdle) && !M_AXI_ARESET;
    m_axi.M_AXI_AWVALID = (state_q == StWrReq) && !aw_done_q && !M_AXI_ARESET;
    m_axi.M_AXI_WVALID  = (state_q == StWrReq) && !w_done_q && !M_AXI_ARESET;
    m_axi.M_AXI_BREADY  = (state_q == StWrResp) && !M_AXI_ARESET;
    m_axi.M_AXI_ARVALID = (state_q == StRdReq) && !M_AXI_ARESET;
    m_axi.M_AXI_RREADY  = (state_q == StRdData) && !M_AXI_ARESET;
    rsp_valid           = (state_q == StDone) && !M_AXI_ARESET;
  end

  assign m_axi.M_AXI_AWADDR = addr_q;
  assign m_axi.M_AXI_ARADDR = addr_q;
  assign m_axi.M_AXI_AWPROT = 3'b000;
  assign m_axi.M_AXI_ARPROT = 3'b000;
  assign m_axi.M_AXI_WDATA  = wdata_q;
  assign m_axi.M_AXI_WSTRB  = '1;

  assign aw_hs = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
  assign w_hs  = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;
  assign b_hs  = m_axi.M_AXI_BVALID && m_axi.M_AXI_BREADY;
  assign ar_hs = m_axi.M_AXI_ARVALID && m_axi.M_AXI_ARREADY;
  assign r_hs  = m_axi.M_AXI_RVALID && m_axi.M_AXI_RREADY;

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            busy;

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign rsp_timeout = rsp_timeout_q;
`else
  // Watchdog limit only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign rsp_timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr << 2;
          wdata_d   = cmd_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        // AW and W complete independently; move on once both have.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (b_hs) begin
          rsp_resp_d  = m_axi.M_AXI_BRESP;
          rsp_rdata_d = '0;
          state_d     = StDone;
        end
      end
      StRdReq: begin
        if (ar_hs) state_d = StRdData;
      end
      StRdData: begin
        if (r_hs) begin
          rsp_resp_d  = m_axi.M_AXI_RRESP;
          rsp_rdata_d = m_axi.M_AXI_RDATA;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    if (state_q == StIdle && cmd_valid && cmd_ready) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q != StIdle && state_d == StDone) begin
      rsp_timeout_d = 1'b0;
    end
    // A real completion in the limit cycle wins over the watchdog.
    if (busy && cnt_q == CntLast && state_d != StDone) begin
      state_d       = StDone;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master: directed and randomized write/read transactions
// against a cycle-scheduled slave model; expected handshake counts and response timing are
// computed arithmetically from the slave wait counts.
module tb_axil_cfg_master;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  axil_cfg_master_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus ();

  axil_cfg_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte address the master must drive for a word index: index*4 modulo the address space.
  function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] a);
    return AW'((32'(a) * 4) % (1 << AW));
  endfunction

  task automatic slave_idle();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
  endtask

  // Presents a command (called #1 after a rising edge); returns #1 after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string tag);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scramble the command bus so any unregistered use of it shows up.
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
  endtask

  // Write with the slave holding AWREADY/WREADY off for aw_w/w_w cycles and BVALID off for b_w
  // cycles after both handshakes. Cycle 1 is the cycle after the accepting edge; counting the
  // accept cycle itself, a zero-wait write reports in its 4th cycle.
  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int aw_w,
                           input int w_w, input int b_w, input logic [1:0] br, input string tag);
    bit aw_done = 0, w_done = 0, b_done = 0;
    bit aw_hs, w_hs, b_hs;
    int bstart = 0, awv = 0, wv = 0, brdy = 0, rsp_n = 0, rsp_c = 0;
    int exp_rsp = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
    logic ok_bus = 1'b1;
    logic [DW-1:0] rd = '0;
    logic [1:0] rr = '0;
    logic to = 1'b0;
    issue(1'b1, a, d, tag);
    for (int c = 1; c <= exp_rsp + 3; c++) begin
      bus.M_AXI_AWREADY = !aw_done && (c >= 1 + aw_w);
      bus.M_AXI_WREADY  = !w_done && (c >= 1 + w_w);
      bus.M_AXI_BVALID  = aw_done && w_done && !b_done && (c >= bstart + b_w);
      bus.M_AXI_BRESP   = br;
      #1;
      if (bus.M_AXI_AWVALID) begin
        awv++;
        if (bus.M_AXI_AWADDR !== byte_addr(a) || bus.M_AXI_AWPROT !== 3'b000) ok_bus = 1'b0;
      end
      if (bus.M_AXI_WVALID) begin
        wv++;
        if (bus.M_AXI_WDATA !== d || bus.M_AXI_WSTRB !== 4'hf) ok_bus = 1'b0;
      end
      if (bus.M_AXI_BREADY) brdy++;
      if (bus.M_AXI_ARVALID || bus.M_AXI_RREADY) ok_bus = 1'b0;
      if (rsp_valid) begin
        rsp_n++; rsp_c = c; rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
      end
      aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (b_hs)  b_done = 1;
      if (aw_done && w_done && bstart == 0) bstart = c + 1;
    end
    slave_idle();
    chk({tag, ".awvalid_cycles"}, awv, aw_w + 1);
    chk({tag, ".wvalid_cycles"}, wv, w_w + 1);
    chk({tag, ".bready_cycles"}, brdy, b_w + 1);
    chk({tag, ".aw_w_bus"}, 32'(ok_bus), 32'd1);
    chk({tag, ".rsp_pulses"}, rsp_n, 1);
    chk({tag, ".rsp_cycle"}, rsp_c, exp_rsp);
    chk({tag, ".rsp_rdata"}, rd, 32'd0);
    chk({tag, ".rsp_resp"}, 32'(rr), 32'(br));
    chk({tag, ".rsp_timeout"}, 32'(to), 32'd0);
    chk({tag, ".resp_held"}, 32'(rsp_resp), 32'(br));
  endtask

  // Read with ARREADY off for ar_w cycles and RVALID off for r_w cycles after the AR handshake.
  // With spur set, the slave drives a stray RVALID before the address phase ends.
  task automatic run_read(input logic [AW-1:0] a, input int ar_w, input int r_w,
                          input logic [1:0] rresp, input logic [DW-1:0] rdata, input bit spur,
                          input string tag);
    bit ar_done = 0, r_done = 0;
    bit ar_hs, r_hs;
    int rstart = 0, arv = 0, rrdy = 0, rsp_n = 0, rsp_c = 0;
    int exp_rsp = 3 + ar_w + r_w;
    logic ok_bus = 1'b1;
    logic [DW-1:0] rd = '0;
    logic [1:0] rr = '0;
    logic to = 1'b0;
    issue(1'b0, a, DW'($urandom), tag);
    for (int c = 1; c <= exp_rsp + 3; c++) begin
      bus.M_AXI_ARREADY = !ar_done && (c >= 1 + ar_w);
      if (ar_done && !r_done && c >= rstart + r_w) begin
        bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = rdata; bus.M_AXI_RRESP = rresp;
      end else if (spur && !ar_done) begin
        bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = 32'hBAD0_BAD0; bus.M_AXI_RRESP = 2'b11;
      end else begin
        bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = 2'b00;
      end
      #1;
      if (bus.M_AXI_ARVALID) begin
        arv++;
        if (bus.M_AXI_ARADDR !== byte_addr(a) || bus.M_AXI_ARPROT !== 3'b000) ok_bus = 1'b0;
      end
      if (bus.M_AXI_RREADY) rrdy++;
      if (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY) ok_bus = 1'b0;
      if (rsp_valid) begin
        rsp_n++; rsp_c = c; rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
      end
      ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
      r_hs  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
      @(posedge clk); #1;
      if (ar_hs) begin ar_done = 1; rstart = c + 1; end
      if (r_hs) r_done = 1;
    end
    slave_idle();
    chk({tag, ".arvalid_cycles"}, arv, ar_w + 1);
    chk({tag, ".rready_cycles"}, rrdy, r_w + 1);
    chk({tag, ".ar_bus"}, 32'(ok_bus), 32'd1);
    chk({tag, ".rsp_pulses"}, rsp_n, 1);
    chk({tag, ".rsp_cycle"}, rsp_c, exp_rsp);
    chk({tag, ".rsp_rdata"}, rd, rdata);
    chk({tag, ".rsp_resp"}, 32'(rr), 32'(rresp));
    chk({tag, ".rsp_timeout"}, 32'(to), 32'd0);
    chk({tag, ".rdata_held"}, rsp_rdata, rdata);
  endtask

  initial begin
    int arv, rsp_n, rsp_c;
    logic bad;
    logic [1:0] rr;
    logic to;
    logic [DW-1:0] rd;
    slave_idle();

    // Reset: outputs quiet and cmd_ready low while reset is held.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset.valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 32'd0);
    chk("reset.readies", 32'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'd0);
    chk("reset.rsp", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.awaddr", 32'(bus.M_AXI_AWADDR), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);

    // Directed cases.
    run_write(5'd2, 32'h0000_0100, 0, 0, 0, 2'b00, "wr_zero_wait");
    run_write(5'd1, 32'hCAFE_0001, 5, 0, 0, 2'b00, "wr_aw_late");
    run_write(5'd4, 32'h1234_5678, 0, 3, 1, 2'b00, "wr_w_late");
    run_read(5'd3, 0, 3, 2'b00, 32'hDEAD_BEEF, 1'b0, "rd_wait3");
    run_write(5'd6, 32'hA5A5_5A5A, 1, 1, 2, 2'b10, "wr_slverr");
    run_read(5'd7, 2, 0, 2'b11, 32'h0BAD_F00D, 1'b1, "rd_decerr_spur");

    // Randomized transactions.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(AW'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), 2'($urandom_range(0, 3)), $sformatf("rand%0d_wr", i));
      else
        run_read(AW'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                 $sformatf("rand%0d_rd", i));
    end

    // Reset while waiting for BRESP: abandoned silently, next command runs normally.
    run_read(5'd5, 0, 0, 2'b01, 32'h7777_1111, 1'b0, "rd_before_rst");
    issue(1'b1, 5'd1, 32'h5555_AAAA, "rst_wr");
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    @(posedge clk); #1;
    slave_idle();
    chk("rst_wr.bready_before", 32'(bus.M_AXI_BREADY), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_wr.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr.handshakes", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                  bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 32'd0);
    chk("rst_wr.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wr.rsp_resp", 32'(rsp_resp), 32'd0);
    // A late BVALID for the abandoned write must be ignored.
    bus.M_AXI_BVALID = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp_valid || bus.M_AXI_BREADY) bad = 1'b1;
    end
    slave_idle();
    chk("rst_wr.no_rsp", 32'(bad), 32'd0);
    @(posedge clk); #1;
    run_write(5'd3, 32'h0F0F_F0F0, 0, 0, 0, 2'b00, "post_rst_wr");

    // Slave never accepts the read address.
    issue(1'b0, 5'd2, '0, "stall_rd");
    arv = 0; rsp_n = 0; rsp_c = 0; rr = '0; to = 1'b0; rd = '1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.M_AXI_ARVALID) arv++;
      if (rsp_valid) begin
        rsp_n++; rsp_c = c; rr = rsp_resp; to = rsp_timeout; rd = rsp_rdata;
      end
      @(posedge clk); #1;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("timeout.arvalid_cycles", arv, TO);
    chk("timeout.rsp_pulses", rsp_n, 1);
    chk("timeout.rsp_cycle", rsp_c, TO + 1);
    chk("timeout.rsp_timeout", 32'(to), 32'd1);
    chk("timeout.rsp_resp", 32'(rr), 32'd2);
    chk("timeout.rsp_rdata", rd, 32'd0);
`else
    chk("stall.arvalid_cycles", arv, 40);
    chk("stall.rsp_pulses", rsp_n, 0);
    chk("stall.arvalid_now", 32'(bus.M_AXI_ARVALID), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    @(posedge clk); #1;
    run_read(5'd1, 1, 1, 2'b00, 32'h0123_4567, 1'b0, "final_rd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
